stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_stack_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//   LIFO stack controller with DEPTH x WIDTH register storage, a registered
//   top-of-stack output and sticky overflow/underflow flags.
//
//   Ports
//     Clk    in   1      single clock, all state updates on rising edge
//     Clr    in   1      synchronous active-high clear (priority over ops)
//     Push   in   1      push request, Din written when accepted
//     Pop    in   1      pop request, top entry removed when accepted
//     Din    in   WIDTH  data to push
//     Dout   out  WIDTH  registered top-of-stack value, 0 when empty
//     Empty  out  1      stack holds no entries
//     Full   out  1      stack holds DEPTH entries
//     Count  out  CW     number of valid entries, 0..DEPTH
//     Ovf    out  1      sticky: push attempted while full (no pop)
//     Udf    out  1      sticky: pop attempted while empty (no push)
//
//   Push+Pop together replaces the top entry; on an empty stack it acts as
//   a plain push. Neither combination touches the sticky flags.
// ---------------------------------------------------------------------------
module stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Push,
    input  logic             Pop,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             Empty,
    output logic             Full,
    output logic [CW-1:0]    Count,
    output logic             Ovf,
    output logic             Udf
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_MID   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;          // next free slot, equals entry count
    logic [CW-1:0]    sp_m1;       // index of current top entry
    logic [AW-1:0]    sp_m2;       // index of entry just below the top
    logic [WIDTH-1:0] dout_r;
    logic             ovf_r;
    logic             udf_r;

    logic             is_empty;
    logic             is_full;
    logic             do_push;
    logic             do_replace;
    logic             do_pop;
    logic             push_blocked;
    logic             pop_blocked;

    assign is_empty = (state == S_EMPTY);
    assign is_full  = (state == S_FULL);

    assign sp_m1 = sp - CW'(1);
    // Only meaningful when sp >= 2, so the low address bits suffice.
    assign sp_m2 = sp[AW-1:0] - AW'(2);

    // Operation decode. Push+Pop on an empty stack degrades to a push;
    // on a non-empty (including full) stack it rewrites the top slot.
    always_comb begin
        do_push      = 1'b0;
        do_replace   = 1'b0;
        do_pop       = 1'b0;
        push_blocked = 1'b0;
        pop_blocked  = 1'b0;
        if (Push && Pop) begin
            if (is_empty) begin
                do_push = 1'b1;
            end else begin
                do_replace = 1'b1;
            end
        end else if (Push) begin
            if (is_full) begin
                push_blocked = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end else if (Pop) begin
            if (is_empty) begin
                pop_blocked = 1'b1;
            end else begin
                do_pop = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_EMPTY: begin
                if (do_push) begin
                    next_state = S_MID;
                end
            end
            S_MID: begin
                if (do_push && (sp == CW'(DEPTH - 1))) begin
                    next_state = S_FULL;
                end else if (do_pop && (sp == CW'(1))) begin
                    next_state = S_EMPTY;
                end
            end
            S_FULL: begin
                if (do_pop) begin
                    next_state = S_MID;
                end
            end
            default: next_state = S_EMPTY;
        endcase
    end

    // Storage: not cleared by Clr, entries above sp are never observed.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            if (do_push) begin
                mem[sp[AW-1:0]] <= Din;
            end else if (do_replace) begin
                mem[sp_m1[AW-1:0]] <= Din;
            end
        end
    end

    // Stack pointer, registered top-of-stack and sticky flags
    always_ff @(posedge Clk) begin
        if (Clr) begin
            sp     <= '0;
            dout_r <= '0;
            ovf_r  <= 1'b0;
            udf_r  <= 1'b0;
        end else begin
            if (do_push) begin
                sp     <= sp + CW'(1);
                dout_r <= Din;
            end else if (do_replace) begin
                dout_r <= Din;
            end else if (do_pop) begin
                sp     <= sp_m1;
                // New top is the entry below the one being removed.
                dout_r <= (sp >= CW'(2)) ? mem[sp_m2] : '0;
            end
            if (push_blocked) begin
                ovf_r <= 1'b1;
            end
            if (pop_blocked) begin
                udf_r <= 1'b1;
            end
        end
    end

    assign Dout  = dout_r;
    assign Count = sp;
    assign Empty = is_empty;
    assign Full  = is_full;
    assign Ovf   = ovf_r;
    assign Udf   = udf_r;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             Clk = 1'b0;
    logic             Clr = 1'b1;
    logic             Push = 1'b0;
    logic             Pop = 1'b0;
    logic [WIDTH-1:0] Din = '0;
    logic [WIDTH-1:0] Dout;
    logic             Empty;
    logic             Full;
    logic [CW-1:0]    Count;
    logic             Ovf;
    logic             Udf;

    int checks = 0;
    int errors = 0;

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .Push  (Push),
        .Pop   (Pop),
        .Din   (Din),
        .Dout  (Dout),
        .Empty (Empty),
        .Full  (Full),
        .Count (Count),
        .Ovf   (Ovf),
        .Udf   (Udf)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       clr;
        logic       push;
        logic       pop;
        logic [7:0] din;
        int         count;
        int         dout;
        int         empty;
        int         full;
        int         ovf;
        int         udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add_v(input logic clr, input logic push, input logic pop,
                         input logic [7:0] din, input int cnt, input int dout,
                         input int ovf, input int udf);
        vec_t v;
        v.clr   = clr;
        v.push  = push;
        v.pop   = pop;
        v.din   = din;
        v.count = cnt;
        v.dout  = dout;
        v.empty = (cnt == 0) ? 1 : 0;
        v.full  = (cnt == DEPTH) ? 1 : 0;
        v.ovf   = ovf;
        v.udf   = udf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input int dout,
                           input int empty, input int full, input int ovf, input int udf);
        chk({tag, ".count"}, int'(Count), cnt);
        chk({tag, ".dout"},  int'(Dout),  dout);
        chk({tag, ".empty"}, int'(Empty), empty);
        chk({tag, ".full"},  int'(Full),  full);
        chk({tag, ".ovf"},   int'(Ovf),   ovf);
        chk({tag, ".udf"},   int'(Udf),   udf);
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic clr, input logic push, input logic pop,
                        input logic [7:0] din);
        Clr  = clr;
        Push = push;
        Pop  = pop;
        Din  = din;
        @(posedge Clk);
        #1;
    endtask

    // Behavioural reference: a queue whose back is the top of stack.
    int unsigned mq[$];
    int          m_ovf;
    int          m_udf;

    task automatic model_step(input logic clr, input logic push, input logic pop,
                              input logic [7:0] din);
        if (clr) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
        end else if (push && pop) begin
            if (mq.size() == 0) mq.push_back(din);
            else mq[mq.size()-1] = din;
        end else if (push) begin
            if (mq.size() < DEPTH) mq.push_back(din);
            else m_ovf = 1;
        end else if (pop) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else m_udf = 1;
        end
    endtask

    initial begin
        // Directed table
        add_v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add_v(0, 1, 0, 8'h11, 1, 8'h11, 0, 0);
        add_v(0, 1, 0, 8'h22, 2, 8'h22, 0, 0);
        add_v(0, 1, 0, 8'h33, 3, 8'h33, 0, 0);
        add_v(0, 0, 0, 8'hEE, 3, 8'h33, 0, 0);   // Din ignored while idle
        add_v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 8; i++) add_v(0, 1, 0, 8'(i), i, i, 0, 0);
        add_v(0, 1, 0, 8'h09, 8, 8'h08, 1, 0);   // overflow attempt
        for (int k = 1; k <= 8; k++) add_v(0, 0, 1, 8'h00, 8 - k, 8 - k, 1, 0);
        add_v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add_v(0, 0, 1, 8'h00, 0, 8'h00, 0, 1);   // underflow
        add_v(0, 1, 1, 8'h5A, 1, 8'h5A, 0, 1);   // push+pop on empty = push
        add_v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add_v(0, 1, 0, 8'hA0, 1, 8'hA0, 0, 0);
        add_v(0, 1, 0, 8'hB0, 2, 8'hB0, 0, 0);
        add_v(0, 1, 1, 8'hC0, 2, 8'hC0, 0, 0);   // replace top
        add_v(0, 0, 1, 8'h00, 1, 8'hA0, 0, 0);
        add_v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) add_v(0, 1, 0, 8'(8'h10 + i), i + 1, 8'h10 + i, 0, 0);
        add_v(0, 1, 1, 8'hFF, 8, 8'hFF, 0, 0);   // replace while full, no ovf
        add_v(0, 1, 0, 8'h44, 8, 8'hFF, 1, 0);
        add_v(0, 0, 1, 8'h00, 7, 8'h16, 1, 0);
        add_v(0, 0, 1, 8'h00, 6, 8'h15, 1, 0);
        add_v(0, 0, 1, 8'h00, 5, 8'h14, 1, 0);
        add_v(1, 1, 0, 8'h77, 0, 8'h00, 0, 0);   // Clr beats Push

        for (int n = 0; n < vecs.size(); n++) begin
            step(vecs[n].clr, vecs[n].push, vecs[n].pop, vecs[n].din);
            chk_all($sformatf("vec%0d", n), vecs[n].count, vecs[n].dout,
                    vecs[n].empty, vecs[n].full, vecs[n].ovf, vecs[n].udf);
        end

        // Hand-written multi-cycle: pop chain to empty then push reuses slot 0
        step(0, 1, 0, 8'h61);
        step(0, 1, 0, 8'h62);
        step(0, 0, 1, 8'h00);
        chk_all("seq_pop1", 1, 8'h61, 0, 0, 0, 0);
        step(0, 0, 1, 8'h00);
        chk_all("seq_pop0", 0, 8'h00, 1, 0, 0, 0);
        step(0, 1, 0, 8'h63);
        chk_all("seq_repush", 1, 8'h63, 0, 0, 0, 0);

        // Randomized phase against the queue model
        step(1, 0, 0, 8'h00);
        model_step(1, 0, 0, 8'h00);
        for (int c = 0; c < 3000; c++) begin
            int   push_pct;
            int   pop_pct;
            logic r_clr;
            logic r_push;
            logic r_pop;
            logic [7:0] r_din;
            int   exp_cnt;
            int   exp_dout;
            case ((c / 60) % 3)
                0:       begin push_pct = 80; pop_pct = 25; end
                1:       begin push_pct = 20; pop_pct = 80; end
                default: begin push_pct = 50; pop_pct = 50; end
            endcase
            r_clr  = ($urandom_range(199) == 0);
            r_push = ($urandom_range(99) < push_pct);
            r_pop  = ($urandom_range(99) < pop_pct);
            r_din  = 8'($urandom);
            step(r_clr, r_push, r_pop, r_din);
            model_step(r_clr, r_push, r_pop, r_din);
            exp_cnt  = mq.size();
            exp_dout = (mq.size() > 0) ? int'(mq[mq.size()-1]) : 0;
            chk_all($sformatf("rnd%0d", c), exp_cnt, exp_dout,
                    (exp_cnt == 0) ? 1 : 0, (exp_cnt == DEPTH) ? 1 : 0, m_ovf, m_udf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
